// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main controller: FSM states, opcodes,
// funct codes and datapath mux/ALU select values.
package mc_defs;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    localparam logic [1:0] RDST_RT  = 2'b00;
    localparam logic [1:0] RDST_RD  = 2'b01;
    localparam logic [1:0] RDST_RA  = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to one-hot class flags.
module mc_decode
    import mc_defs::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic       is_rtype_alu_o,
    output logic       is_ori_o,
    output logic       is_lui_o,
    output logic       is_lw_o,
    output logic       is_sw_o,
    output logic       is_beq_o,
    output logic       is_j_o,
    output logic       is_jal_o,
    output logic       is_jr_o,
    output logic       is_unknown_o
);

    // Classify opcode, then funct for the R-type group.
    always_comb begin
        is_rtype_alu_o = 1'b0;
        is_ori_o       = 1'b0;
        is_lui_o       = 1'b0;
        is_lw_o        = 1'b0;
        is_sw_o        = 1'b0;
        is_beq_o       = 1'b0;
        is_j_o         = 1'b0;
        is_jal_o       = 1'b0;
        is_jr_o        = 1'b0;
        is_unknown_o   = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU, FN_SUBU: is_rtype_alu_o = 1'b1;
                    FN_JR:            is_jr_o        = 1'b1;
                    default:          is_unknown_o   = 1'b1;
                endcase
            end
            OP_ORI:  is_ori_o     = 1'b1;
            OP_LUI:  is_lui_o     = 1'b1;
            OP_LW:   is_lw_o      = 1'b1;
            OP_SW:   is_sw_o      = 1'b1;
            OP_BEQ:  is_beq_o     = 1'b1;
            OP_J:    is_j_o       = 1'b1;
            OP_JAL:  is_jal_o     = 1'b1;
            default: is_unknown_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset main controller (FETCH/DECODE/EXEC/MEM/WB).
// Optional MC_ILLEGAL_TRAP_EN: unknown instructions halt and raise illegal.
module mc_ctrl
    import mc_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    output logic             pc_we,
    output logic             ir_we,
    output logic             grf_we,
    output logic             dm_we,
    output logic [1:0]       npc_sel,
    output logic [2:0]       alu_op,
    output logic             alu_src_b,
    output logic             ext_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             pc_en_s, ir_en_s, grf_en_s, dm_en_s, retire_s;
    logic             is_rtype_alu_s, is_ori_s, is_lui_s, is_lw_s, is_sw_s;
    logic             is_beq_s, is_j_s, is_jal_s, is_jr_s, is_unknown_s;
    logic             unused_instr_s;

    assign unused_instr_s = ^instr[25:6];

    mc_decode u_decode (
        .op_i           (instr[31:26]),
        .funct_i        (instr[5:0]),
        .is_rtype_alu_o (is_rtype_alu_s),
        .is_ori_o       (is_ori_s),
        .is_lui_o       (is_lui_s),
        .is_lw_o        (is_lw_s),
        .is_sw_o        (is_sw_s),
        .is_beq_o       (is_beq_s),
        .is_j_o         (is_j_s),
        .is_jal_o       (is_jal_s),
        .is_jr_o        (is_jr_s),
        .is_unknown_o   (is_unknown_s)
    );

    // State and retired-instruction counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state, write enables, PC and write-back selects.
    always_comb begin
        state_d  = ST_FETCH;
        pc_en_s  = 1'b0;
        ir_en_s  = 1'b0;
        grf_en_s = 1'b0;
        dm_en_s  = 1'b0;
        retire_s = 1'b0;
        npc_sel  = NPC_PC4;
        reg_dst  = RDST_RT;
        wd_sel   = WD_ALU;
        case (state_q)
            ST_FETCH: begin
                ir_en_s = 1'b1;
                pc_en_s = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_j_s || is_jal_s) begin
                    pc_en_s  = 1'b1;
                    npc_sel  = NPC_JMP;
                    grf_en_s = is_jal_s;
                    reg_dst  = is_jal_s ? RDST_RA : RDST_RT;
                    wd_sel   = is_jal_s ? WD_PC : WD_ALU;
                    retire_s = 1'b1;
                end else if (is_jr_s) begin
                    pc_en_s  = 1'b1;
                    npc_sel  = NPC_RS;
                    retire_s = 1'b1;
                end else if (is_unknown_s) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d  = ST_HALT;
`else
                    retire_s = 1'b1;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_beq_s) begin
                    pc_en_s  = zero;
                    npc_sel  = NPC_BR;
                    retire_s = 1'b1;
                end else if (is_lw_s || is_sw_s) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (is_sw_s) begin
                    dm_en_s  = 1'b1;
                    retire_s = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                grf_en_s = 1'b1;
                retire_s = 1'b1;
                reg_dst  = is_rtype_alu_s ? RDST_RD : RDST_RT;
                wd_sel   = is_lw_s ? WD_DM : WD_ALU;
            end
            ST_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
                state_d = ST_HALT;
`else
                state_d = ST_FETCH;
`endif
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // ALU controls follow the instruction class for the whole EXEC..WB span.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        ext_op    = 1'b0;
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            if (is_rtype_alu_s) begin
                alu_op = (instr[5:0] == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end else if (is_ori_s || is_lui_s) begin
                alu_op    = is_ori_s ? ALU_OR : ALU_LUI;
                alu_src_b = 1'b1;
            end else if (is_lw_s || is_sw_s) begin
                alu_src_b = 1'b1;
                ext_op    = 1'b1;
            end else if (is_beq_s) begin
                alu_op = ALU_SUB;
            end else begin
                alu_op = ALU_ADD;
            end
        end else begin
            alu_op = ALU_ADD;
        end
    end

    // Counter advances on the cycle that hands control back to FETCH.
    always_comb begin
        if (retire_s) begin
            retired_d = retired_q + CNT_W'(1'b1);
        end else begin
            retired_d = retired_q;
        end
    end

    assign pc_we   = pc_en_s  & ~reset;
    assign ir_we   = ir_en_s  & ~reset;
    assign grf_we  = grf_en_s & ~reset;
    assign dm_we   = dm_en_s  & ~reset;
    assign state   = state_q;
    assign retired = retired_q;
`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = (state_q == ST_HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random instruction
// streams compared cycle by cycle against a per-instruction expectation table.
module tb_mc_ctrl;

    localparam int TB_CNT_W = 4;

    logic                clk;
    logic                reset;
    logic [31:0]         instr;
    logic                zero;
    logic                pc_we, ir_we, grf_we, dm_we;
    logic [1:0]          npc_sel;
    logic [2:0]          alu_op;
    logic                alu_src_b, ext_op;
    logic [1:0]          reg_dst, wd_sel;
    logic [2:0]          state;
    logic [TB_CNT_W-1:0] retired;
    logic                illegal;

    int checks = 0;
    int errors = 0;
    logic [TB_CNT_W-1:0] model_ret = '0;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we, ir_we, grf_we, dm_we;
        logic       care_npc;
        logic [1:0] npc;
        logic       care_alu;
        logic [2:0] aop;
        logic       srcb, ext;
        logic       care_wb;
        logic [1:0] rdst, wds;
    } exp_t;

    exp_t exp_q[$];

    mc_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .zero      (zero),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .grf_we    (grf_we),
        .dm_we     (dm_we),
        .npc_sel   (npc_sel),
        .alu_op    (alu_op),
        .alu_src_b (alu_src_b),
        .ext_op    (ext_op),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .state     (state),
        .retired   (retired),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic known(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) return (fn == 6'h21 || fn == 6'h23 || fn == 6'h08);
        return (op == 6'h0D || op == 6'h0F || op == 6'h23 || op == 6'h2B ||
                op == 6'h04 || op == 6'h02 || op == 6'h03);
    endfunction

    // Expected per-cycle behaviour of one instruction, from the instruction rules.
    task automatic build(input logic [31:0] ins, input logic z);
        logic [5:0] op, fn;
        exp_t e, a;
        op = ins[31:26];
        fn = ins[5:0];
        exp_q.delete();
        e = '0; e.st = 3'd0; e.pc_we = 1'b1; e.ir_we = 1'b1; e.care_npc = 1'b1; e.npc = 2'b00;
        exp_q.push_back(e);
        e = '0; e.st = 3'd1;
        if (op == 6'h02 || op == 6'h03) begin
            e.pc_we = 1'b1; e.care_npc = 1'b1; e.npc = 2'b10;
            if (op == 6'h03) begin
                e.grf_we = 1'b1; e.care_wb = 1'b1; e.rdst = 2'b10; e.wds = 2'b10;
            end
            exp_q.push_back(e);
        end else if (op == 6'h00 && fn == 6'h08) begin
            e.pc_we = 1'b1; e.care_npc = 1'b1; e.npc = 2'b11;
            exp_q.push_back(e);
        end else if (!known(ins)) begin
            exp_q.push_back(e);
        end else begin
            exp_q.push_back(e);
            a = '0; a.care_alu = 1'b1;
            case (op)
                6'h00:        a.aop = (fn == 6'h23) ? 3'b001 : 3'b000;
                6'h0D:        begin a.aop = 3'b010; a.srcb = 1'b1; end
                6'h0F:        begin a.aop = 3'b011; a.srcb = 1'b1; end
                6'h23, 6'h2B: begin a.aop = 3'b000; a.srcb = 1'b1; a.ext = 1'b1; end
                6'h04:        a.aop = 3'b001;
                default:      a.aop = 3'b000;
            endcase
            e = a; e.st = 3'd2;
            if (op == 6'h04) begin
                e.pc_we = z; e.care_npc = 1'b1; e.npc = 2'b01;
            end
            exp_q.push_back(e);
            if (op == 6'h23 || op == 6'h2B) begin
                e = a; e.st = 3'd3; e.dm_we = (op == 6'h2B);
                exp_q.push_back(e);
            end
            if (op != 6'h04 && op != 6'h2B) begin
                e = a; e.st = 3'd4; e.grf_we = 1'b1; e.care_wb = 1'b1;
                e.rdst = (op == 6'h00) ? 2'b01 : 2'b00;
                e.wds  = (op == 6'h23) ? 2'b01 : 2'b00;
                exp_q.push_back(e);
            end
        end
    endtask

    // Run one instruction from FETCH and compare every cycle against the table.
    task automatic run_instr(input logic [31:0] ins, input logic z, input string name);
        exp_t e;
        build(ins, z);
        instr = ins;
        zero  = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            @(negedge clk);
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL %s[%0d] state: got %0d expected %0d", name, i, state, e.st);
            end
            checks++;
            if ({pc_we, ir_we, grf_we, dm_we} !== {e.pc_we, e.ir_we, e.grf_we, e.dm_we}) begin
                errors++;
                $display("FAIL %s[%0d] we(pc,ir,grf,dm): got %b expected %b", name, i,
                         {pc_we, ir_we, grf_we, dm_we}, {e.pc_we, e.ir_we, e.grf_we, e.dm_we});
            end
            checks++;
            if (retired !== model_ret || illegal !== 1'b0) begin
                errors++;
                $display("FAIL %s[%0d] retired/illegal: got %0d/%b expected %0d/0", name, i,
                         retired, illegal, model_ret);
            end
            if (e.care_npc) begin
                checks++;
                if (npc_sel !== e.npc) begin
                    errors++;
                    $display("FAIL %s[%0d] npc_sel: got %b expected %b", name, i, npc_sel, e.npc);
                end
            end
            if (e.care_alu) begin
                checks++;
                if ({alu_op, alu_src_b, ext_op} !== {e.aop, e.srcb, e.ext}) begin
                    errors++;
                    $display("FAIL %s[%0d] alu(op,srcb,ext): got %b expected %b", name, i,
                             {alu_op, alu_src_b, ext_op}, {e.aop, e.srcb, e.ext});
                end
            end
            if (e.care_wb) begin
                checks++;
                if ({reg_dst, wd_sel} !== {e.rdst, e.wds}) begin
                    errors++;
                    $display("FAIL %s[%0d] wb(reg_dst,wd_sel): got %b expected %b", name, i,
                             {reg_dst, wd_sel}, {e.rdst, e.wds});
                end
            end
            @(posedge clk); #1;
        end
        model_ret = model_ret + TB_CNT_W'(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({pc_we, ir_we, grf_we, dm_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_we0: got %b expected 0000", {pc_we, ir_we, grf_we, dm_we});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || retired !== '0 || illegal !== 1'b0 ||
            {pc_we, ir_we, grf_we, dm_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got st=%0d ret=%0d ill=%b we=%b expected 0/0/0/0000",
                     state, retired, illegal, {pc_we, ir_we, grf_we, dm_we});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_ret = '0;
    endtask

    task automatic test_ori();
        run_instr(32'h34011234, 1'b0, "ori");
    endtask

    task automatic test_lw();
        run_instr(32'h8C040004, 1'b0, "lw");
    endtask

    task automatic test_beq();
        run_instr(32'h10210003, 1'b1, "beq_taken");
        run_instr(32'h10210003, 1'b0, "beq_not_taken");
    endtask

    task automatic test_jal();
        run_instr(32'h0C000C01, 1'b0, "jal");
    endtask

    task automatic test_unknown();
`ifdef MC_ILLEGAL_TRAP_EN
        instr = 32'hFC000000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd5 || illegal !== 1'b1 || retired !== model_ret ||
                {pc_we, ir_we, grf_we, dm_we} !== 4'b0000) begin
                errors++;
                $display("FAIL halt[%0d]: got st=%0d ill=%b ret=%0d we=%b expected 5/1/%0d/0000",
                         i, state, illegal, retired, model_ret, {pc_we, ir_we, grf_we, dm_we});
            end
            @(posedge clk); #1;
        end
        test_reset();
`else
        run_instr(32'hFC000000, 1'b0, "unknown_op");
        run_instr(32'h00000015, 1'b0, "unknown_funct");
`endif
    endtask

    function automatic logic [31:0] gen(input int k);
        logic [31:0] r;
        logic [5:0]  op;
        r = $urandom;
        case (k)
            0:  gen = {6'h00, r[25:11], 5'd0, 6'h21};
            1:  gen = {6'h00, r[25:11], 5'd0, 6'h23};
            2:  gen = {6'h00, r[25:21], 15'd0, 6'h08};
            3:  gen = {6'h0D, r[25:0]};
            4:  gen = {6'h0F, r[25:0]};
            5:  gen = {6'h23, r[25:0]};
            6:  gen = {6'h2B, r[25:0]};
            7:  gen = {6'h04, r[25:0]};
            8:  gen = {6'h02, r[25:0]};
            9:  gen = {6'h03, r[25:0]};
            10: begin
                op = r[31:26];
                while (known({op, 26'd0}) || op == 6'h00) op = 6'($urandom);
                gen = {op, r[25:0]};
            end
            default: begin
                gen = {6'h00, r[25:6], 6'h3F};
            end
        endcase
    endfunction

    task automatic test_random();
        int hi;
`ifdef MC_ILLEGAL_TRAP_EN
        hi = 9;
`else
        hi = 11;
`endif
        for (int n = 0; n < 60; n++) begin
            run_instr(gen($urandom_range(0, hi)), 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid();
        instr = 32'h8C040004;
        zero  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL reset_mid_in_mem: got state %0d expected 3", state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({pc_we, ir_we, grf_we, dm_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_we0: got %b expected 0000", {pc_we, ir_we, grf_we, dm_we});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_ret = '0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || retired !== '0) begin
            errors++;
            $display("FAIL reset_mid_after: got st=%0d ret=%0d expected 0/0", state, retired);
        end
    endtask

    initial begin
        reset = 1'b1;
        instr = 32'h0;
        zero  = 1'b0;
        test_reset();
        test_ori();
        test_lw();
        test_beq();
        test_jal();
        test_unknown();
        test_random();
        run_instr(32'h00000008, 1'b0, "jr");
        run_instr(32'hAC050008, 1'b0, "sw");
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
